// File: rtl/sobel_frame_sequencer.sv
// sobel_frame_sequencer: walks a frame pixel by pixel, hands each pixel to the
// gray/sobel core and waits (with a bounded timeout) for the core's result.
module sobel_frame_sequencer #(
  parameter int PX_WIDTH = 24,
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic                     clk_i,
  input  logic                     nreset_i,
  input  logic [1:0]               cfg_select_i,
  input  logic                     frame_go_i,
  input  logic                     abort_i,
  input  logic                     px_valid_i,
  input  logic [PX_WIDTH-1:0]      px_data_i,
  output logic                     px_accept_o,
  output logic [1:0]               core_select_o,
  output logic                     core_start_o,
  output logic [PX_WIDTH-1:0]      core_px_o,
  input  logic                     core_px_ready_i,
  output logic [$clog2(IMG_W)-1:0] col_o,
  output logic [$clog2(IMG_H)-1:0] row_o,
  output logic                     busy_o,
  output logic                     frame_done_o,
  output logic                     timeout_err_o
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_ISSUE, ST_WAIT, ST_ADV, ST_DONE, ST_ERR} state_t;

  state_t              state_q;
  logic [1:0]          sel_q;
  logic [PX_WIDTH-1:0] px_q;
  logic [CW-1:0]       col_q;
  logic [RW-1:0]       row_q;
  logic [TW-1:0]       tmo_q;
  logic [TW-1:0]       tmo_d;
  logic                err_q;
  logic                last_col;
  logic                last_row;

  assign tmo_d    = (tmo_q == TW'(TIMEOUT)) ? tmo_q : tmo_q + 1'b1;
  assign last_col = col_q == CW'(IMG_W - 1);
  assign last_row = row_q == RW'(IMG_H - 1);

  // Strobes decode the current state so that an abort can veto them in the same cycle.
  assign px_accept_o   = state_q == ST_LOAD && px_valid_i && !abort_i;
  assign core_start_o  = state_q == ST_ISSUE && !abort_i;
  assign frame_done_o  = state_q == ST_DONE && !abort_i;
  assign busy_o        = !(state_q inside {ST_IDLE, ST_ERR});
  assign core_select_o = sel_q;
  assign core_px_o     = px_q;
  assign col_o         = col_q;
  assign row_o         = row_q;
  assign timeout_err_o = err_q;

  always_ff @(posedge clk_i or negedge nreset_i)
    if (!nreset_i) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      px_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else if (abort_i && state_q != ST_IDLE) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_ERR:
          if (frame_go_i) begin
            state_q <= ST_LOAD;
            sel_q   <= cfg_select_i;
            col_q   <= '0;
            row_q   <= '0;
            err_q   <= 1'b0;
          end
        ST_LOAD:
          if (px_valid_i) begin
            px_q    <= px_data_i;
            state_q <= ST_ISSUE;
          end
        ST_ISSUE: begin
          tmo_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT:
          if (core_px_ready_i) state_q <= ST_ADV;
          else begin
            tmo_q <= tmo_d;
            if (tmo_d == TW'(TIMEOUT)) begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end
          end
        ST_ADV:
          if (last_col && last_row) state_q <= ST_DONE;
          else begin
            col_q   <= last_col ? '0 : col_q + 1'b1;
            row_q   <= last_col ? row_q + 1'b1 : row_q;
            state_q <= ST_LOAD;
          end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// tb_sobel_frame_sequencer: directed + randomized frames on a 4x2 image, checked
// against a pixel-index scoreboard and spec-derived cycle counts.
module tb_sobel_frame_sequencer;
  localparam int W = 4, H = 2, PXW = 24, TMO = 8;

  logic           clk_i = 1'b0;
  logic           nreset_i;
  logic [1:0]     cfg_select_i;
  logic           frame_go_i, abort_i, px_valid_i, core_px_ready_i;
  logic [PXW-1:0] px_data_i;
  logic           px_accept_o, core_start_o, busy_o, frame_done_o, timeout_err_o;
  logic [1:0]     core_select_o;
  logic [PXW-1:0] core_px_o;
  logic [1:0]     col_o;
  logic           row_o;

  sobel_frame_sequencer #(.PX_WIDTH(PXW), .IMG_W(W), .IMG_H(H), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .nreset_i(nreset_i), .cfg_select_i(cfg_select_i), .frame_go_i(frame_go_i),
    .abort_i(abort_i), .px_valid_i(px_valid_i), .px_data_i(px_data_i), .px_accept_o(px_accept_o),
    .core_select_o(core_select_o), .core_start_o(core_start_o), .core_px_o(core_px_o),
    .core_px_ready_i(core_px_ready_i), .col_o(col_o), .row_o(row_o), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .timeout_err_o(timeout_err_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0, miscompares = 0;
  int acc_n = 0, start_n = 0, done_n = 0;
  int idx = 0, wl = 0, lat = 0;
  int a0, s0, d0, n;
  bit noise = 0, busy_prev = 0;
  logic [PXW-1:0] last_px = '0;
  logic [1:0]     exp_sel = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: observe at negedge (scoreboard), then drive the next inputs just after posedge.
  task automatic cycle();
    bit fin;
    @(negedge clk_i);
    if (busy_o && !busy_prev) idx = 0;
    busy_prev = busy_o;
    if (px_accept_o) begin
      acc_n++;
      last_px = px_data_i;
    end
    if (core_start_o) begin
      chk("col_at_start", col_o, idx % W);
      chk("row_at_start", row_o, idx / W);
      chk("sel_at_start", core_select_o, exp_sel);
      chk("px_at_start", core_px_o, last_px);
      idx++;
      start_n++;
      if (lat != 0) wl = (lat < 0) ? $urandom_range(6, 1) : lat;
    end
    fin = frame_done_o;
    if (fin) done_n++;
    @(posedge clk_i);
    #1;
    frame_go_i = 1'b0;
    abort_i    = 1'b0;
    px_data_i  = PXW'($urandom);
    if (wl > 0) begin
      wl--;
      core_px_ready_i = (wl == 0);
    end else core_px_ready_i = noise && !fin && $urandom_range(1, 0) == 1;
    if (noise && !fin) begin
      px_valid_i   = $urandom_range(1, 0) == 1;
      frame_go_i   = $urandom_range(3, 0) == 0;
      cfg_select_i = 2'($urandom);
    end
  endtask

  task automatic run_to_done(input int bound, output int cyc);
    int d = done_n;
    cyc = 0;
    do begin
      cycle();
      cyc++;
    end while (done_n == d && cyc < bound);
    chk("frame_done_count", done_n - d, 1);
  endtask

  task automatic start_frame(input logic [1:0] sel, input int l, input logic v);
    wl = 0;
    core_px_ready_i = 1'b0;
    lat = l;
    px_valid_i = v;
    cfg_select_i = sel;
    exp_sel = sel;
    frame_go_i = 1'b1;
    a0 = acc_n;
    s0 = start_n;
    d0 = done_n;
  endtask

  initial begin
    nreset_i = 1'b1; cfg_select_i = '0; frame_go_i = 0; abort_i = 0;
    px_valid_i = 0; px_data_i = '0; core_px_ready_i = 0;
    #2 nreset_i = 1'b0;
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_err", timeout_err_o, 0);
    chk("rst_sel", core_select_o, 0);
    chk("rst_px", core_px_o, 0);
    chk("rst_col", col_o, 0);
    chk("rst_row", row_o, 0);
    chk("rst_strobes", {px_accept_o, core_start_o, frame_done_o}, 0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1 nreset_i = 1'b1;

    // Full frame at minimum pixel period.
    start_frame(2'd2, 1, 1'b1);
    run_to_done(200, n);
    chk("frame_cycles", n, 2 + 4 * W * H);
    chk("frame_accepts", acc_n - a0, W * H);
    chk("frame_starts", start_n - s0, W * H);
    chk("busy_after_done", busy_o, 0);
    chk("final_col", col_o, W - 1);
    chk("final_row", row_o, H - 1);

    // Random pixel gaps, core latencies, and mid-frame go/cfg/ready noise.
    for (int f = 0; f < 3; f++) begin
      start_frame(2'($urandom), -1, 1'b1);
      noise = 1;
      run_to_done(400, n);
      noise = 0;
      chk("rand_accepts", acc_n - a0, W * H);
      chk("rand_starts", start_n - s0, W * H);
    end

    // Core never answers.
    start_frame(2'd1, 0, 1'b1);
    n = 0;
    do begin cycle(); n++; end while (start_n == s0 && n < 20);
    n = 0;
    do begin cycle(); n++; end while (!timeout_err_o && n < 50);
    chk("timeout_cycles", n, TMO);
    chk("timeout_err", timeout_err_o, 1);
    chk("timeout_busy", busy_o, 0);
    repeat (3) cycle();
    chk("timeout_sticky", timeout_err_o, 1);
    chk("timeout_no_done", done_n - d0, 0);
    start_frame(2'd3, 1, 1'b1);
    cycle();
    chk("restart_err_clr", timeout_err_o, 0);
    chk("restart_busy", busy_o, 1);
    run_to_done(200, n);
    chk("restart_accepts", acc_n - a0, W * H);

    // Abort while waiting on the fifth pixel.
    start_frame(2'd1, 3, 1'b1);
    n = 0;
    do begin cycle(); n++; end while (start_n - s0 < 5 && n < 100);
    abort_i = 1'b1;
    a0 = acc_n;
    cycle();
    chk("abort_busy", busy_o, 0);
    repeat (6) cycle();
    chk("abort_no_done", done_n - d0, 0);
    chk("abort_no_accept", acc_n - a0, 0);
    start_frame(2'd0, 1, 1'b1);
    run_to_done(200, n);
    chk("abort_restart_cycles", n, 2 + 4 * W * H);

    // Pixel source stalls for 10 cycles in LOAD.
    start_frame(2'd2, 1, 1'b0);
    cycle();
    repeat (10) cycle();
    chk("stall_no_accept", acc_n - a0, 0);
    chk("stall_no_start", start_n - s0, 0);
    chk("stall_busy", busy_o, 1);
    px_valid_i = 1'b1;
    cycle();
    chk("stall_one_accept", acc_n - a0, 1);
    cycle();
    chk("stall_still_one", acc_n - a0, 1);
    chk("stall_one_start", start_n - s0, 1);
    run_to_done(200, n);
    chk("stall_accepts", acc_n - a0, W * H);

    // Asynchronous reset while waiting on the third pixel.
    start_frame(2'd2, 4, 1'b1);
    n = 0;
    do begin cycle(); n++; end while (start_n - s0 < 3 && n < 100);
    #2 nreset_i = 1'b0;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_sel", core_select_o, 0);
    chk("arst_px", core_px_o, 0);
    chk("arst_colrow", {col_o, row_o}, 0);
    chk("arst_strobes", {px_accept_o, core_start_o, frame_done_o, timeout_err_o}, 0);
    wl = 0;
    core_px_ready_i = 1'b0;
    @(posedge clk_i);
    #1 nreset_i = 1'b1;
    a0 = acc_n; s0 = start_n; d0 = done_n;
    repeat (10) cycle();
    chk("arst_quiet", {acc_n - a0, start_n - s0, done_n - d0}, 0);
    chk("arst_idle_busy", busy_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
